// File: rtl/udp_pkg.sv
// udp_pkg: shared UDP header constants and receive deframer state encoding
package udp_pkg;
    localparam int UDP_HDR_LEN = 8;
    localparam int OFF_SRC     = 0;
    localparam int OFF_DST     = 2;
    localparam int OFF_LEN     = 4;
    localparam int OFF_CSUM    = 6;
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DISCARD} rx_state_t;
endpackage

// File: rtl/udp_rx_deframer.sv
// udp_rx_deframer: parses the UDP header from the IP payload stream, filters on port, forwards payload
module udp_rx_deframer
    import udp_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT = 16'h1F90,
    parameter bit          CHECK_PORT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ip_rx_valid,
    input  logic        ip_rx_sop,
    input  logic        ip_rx_last,
    input  logic [7:0]  ip_rx_data,
    output logic        udp_rx_valid,
    output logic        udp_rx_sop,
    output logic        udp_rx_eop,
    output logic [7:0]  udp_rx_data,
    output logic [15:0] udp_src_port,
    output logic [15:0] udp_dst_port,
    output logic [15:0] udp_payload_len,
    output logic        udp_rx_drop,
    output logic        udp_rx_err
);
    localparam logic [15:0] HL = 16'(UDP_HDR_LEN);

    rx_state_t   state, state_d;
    logic [2:0]  hdr_cnt, idx;
    logic [15:0] rem, src, dst, len;
    logic [7:0]  hdr_b [OFF_CSUM];
    logic        hdr_done, fwd, eop_d, err_d, drop_d, short_len, port_bad, has_pay;

    assign idx       = ip_rx_sop ? 3'd0 : hdr_cnt;
    assign src       = {hdr_b[OFF_SRC], hdr_b[OFF_SRC+1]};
    assign dst       = {hdr_b[OFF_DST], hdr_b[OFF_DST+1]};
    assign len       = {hdr_b[OFF_LEN], hdr_b[OFF_LEN+1]};
    assign short_len = len < HL;
    assign has_pay   = len > HL;
    assign port_bad  = CHECK_PORT && dst != LOCAL_PORT;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_d;

    // next state plus per-byte decisions; sop always restarts the header
    always_comb begin
        state_d  = state;
        hdr_done = 1'b0;
        fwd      = 1'b0;
        eop_d    = 1'b0;
        err_d    = 1'b0;
        drop_d   = 1'b0;
        if (ip_rx_valid && ip_rx_sop) begin
            state_d = ip_rx_last ? IDLE : HDR;
            err_d   = ip_rx_last || state == PAYLOAD;
        end else if (ip_rx_valid) begin
            case (state)
                HDR:
                    if (hdr_cnt == 3'(UDP_HDR_LEN - 1)) begin
                        hdr_done = 1'b1;
                        err_d    = short_len || (!port_bad && has_pay && ip_rx_last);
                        drop_d   = !short_len && port_bad;
                        state_d  = ip_rx_last ? IDLE :
                                   (!short_len && !port_bad && has_pay) ? PAYLOAD : DISCARD;
                    end else if (ip_rx_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                PAYLOAD: begin
                    fwd     = 1'b1;
                    eop_d   = rem == 16'd1 || ip_rx_last;
                    err_d   = ip_rx_last && rem != 16'd1;
                    state_d = ip_rx_last ? IDLE : rem == 16'd1 ? DISCARD : PAYLOAD;
                end
                DISCARD: state_d = ip_rx_last ? IDLE : DISCARD;
                default: ;
            endcase
        end
    end

    // header capture, byte counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            udp_rx_valid    <= 1'b0;
            udp_rx_sop      <= 1'b0;
            udp_rx_eop      <= 1'b0;
            udp_rx_data     <= '0;
            udp_src_port    <= '0;
            udp_dst_port    <= '0;
            udp_payload_len <= '0;
            udp_rx_drop     <= 1'b0;
            udp_rx_err      <= 1'b0;
            hdr_cnt         <= '0;
            rem             <= '0;
            foreach (hdr_b[i]) hdr_b[i] <= '0;
        end else begin
            udp_rx_valid <= fwd;
            udp_rx_sop   <= fwd && rem == udp_payload_len;
            udp_rx_eop   <= eop_d;
            udp_rx_err   <= err_d;
            udp_rx_drop  <= drop_d;
            if (fwd) begin
                udp_rx_data <= ip_rx_data;
                rem         <= rem - 16'd1;
            end
            if (ip_rx_valid && (ip_rx_sop || state == HDR)) begin
                if (idx < 3'(OFF_CSUM)) hdr_b[idx] <= ip_rx_data;
                hdr_cnt <= idx + 3'd1;
            end
            if (hdr_done) begin
                udp_src_port    <= src;
                udp_dst_port    <= dst;
                udp_payload_len <= short_len ? 16'd0 : len - HL;
                rem             <= short_len ? 16'd0 : len - HL;
            end
        end
    end
endmodule

// File: tb/tb_udp_rx_deframer.sv
// tb_udp_rx_deframer: table-driven, hand-sequenced and randomized checks of the UDP RX deframer
module tb_udp_rx_deframer;
    import udp_pkg::*;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [15:0] src, dst, len;
        int          n, xout, xerr, xdrop;
        logic [15:0] xsrc, xdst, xplen;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ip_rx_valid = 1'b0, ip_rx_sop = 1'b0, ip_rx_last = 1'b0;
    logic [7:0]  ip_rx_data = '0;
    logic        udp_rx_valid, udp_rx_sop, udp_rx_eop, udp_rx_drop, udp_rx_err;
    logic [7:0]  udp_rx_data;
    logic [15:0] udp_src_port, udp_dst_port, udp_payload_len;

    int          nchk = 0, nerr = 0, ecnt = 0, dcnt = 0;
    logic [9:0]  oq[$];
    bit          gaps = 1'b0;
    logic [15:0] m_src, m_dst, m_plen;
    vec_t        tbl[11];

    udp_rx_deframer dut (
        .clk(clk), .rst_n(rst_n),
        .ip_rx_valid(ip_rx_valid), .ip_rx_sop(ip_rx_sop), .ip_rx_last(ip_rx_last), .ip_rx_data(ip_rx_data),
        .udp_rx_valid(udp_rx_valid), .udp_rx_sop(udp_rx_sop), .udp_rx_eop(udp_rx_eop), .udp_rx_data(udp_rx_data),
        .udp_src_port(udp_src_port), .udp_dst_port(udp_dst_port), .udp_payload_len(udp_payload_len),
        .udp_rx_drop(udp_rx_drop), .udp_rx_err(udp_rx_err)
    );

    always #5 clk = ~clk;

    // collect forwarded bytes and pulse counts away from the active edge
    always @(negedge clk) begin
        if (udp_rx_valid) oq.push_back({udp_rx_sop, udp_rx_eop, udp_rx_data});
        if (udp_rx_err) ecnt++;
        if (udp_rx_drop) dcnt++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, udp_rx_valid, 0);
        chk({tag, " sop"}, udp_rx_sop, 0);
        chk({tag, " eop"}, udp_rx_eop, 0);
        chk({tag, " data"}, udp_rx_data, 0);
        chk({tag, " src"}, udp_src_port, 0);
        chk({tag, " dst"}, udp_dst_port, 0);
        chk({tag, " plen"}, udp_payload_len, 0);
        chk({tag, " drop"}, udp_rx_drop, 0);
        chk({tag, " err"}, udp_rx_err, 0);
    endtask

    function automatic bq_t build(input logic [15:0] s, d, l, input int n);
        bq_t f;
        logic [7:0] pat [4];
        pat = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        f = '{s[15:8], s[7:0], d[15:8], d[7:0], l[15:8], l[7:0], 8'h5A, 8'hC3};
        for (int k = 0; f.size() < n; k++) f.push_back(pat[k % 4] ^ 8'(k / 4));
        while (f.size() > n) void'(f.pop_back());
        return f;
    endfunction

    // called just after a rising edge; returns just after the edge that took the byte
    task automatic put(input logic [7:0] b, input logic s, input logic l);
        if (gaps) repeat ($urandom_range(0, 2)) begin
            ip_rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        ip_rx_valid = 1'b1; ip_rx_sop = s; ip_rx_last = l; ip_rx_data = b;
        @(posedge clk); #1;
        ip_rx_valid = 1'b0; ip_rx_sop = 1'b0; ip_rx_last = 1'b0;
    endtask

    task automatic send(input bq_t f);
        foreach (f[i]) put(f[i], i == 0, i == f.size() - 1);
    endtask

    task automatic send_and_check(input bq_t f, input string tag, input int xout, xerr, xdrop,
                                  input logic [15:0] xsrc, xdst, xplen);
        int e0, d0;
        e0 = ecnt; d0 = dcnt; oq.delete();
        send(f);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " nout"}, oq.size(), xout);
        for (int i = 0; i < xout && i < oq.size(); i++) begin
            chk({tag, " data"}, oq[i][7:0], f[8+i]);
            chk({tag, " sop"}, oq[i][9], i == 0);
            chk({tag, " eop"}, oq[i][8], i == xout - 1);
        end
        chk({tag, " err"}, ecnt - e0, xerr);
        chk({tag, " drop"}, dcnt - d0, xdrop);
        chk({tag, " src"}, udp_src_port, xsrc);
        chk({tag, " dst"}, udp_dst_port, xdst);
        chk({tag, " plen"}, udp_payload_len, xplen);
    endtask

    // datagram-level reference: what a whole frame should produce
    task automatic model(input bq_t f, output int xout, xerr, xdrop);
        int n, len;
        n = f.size(); xout = 0; xerr = 0; xdrop = 0;
        if (n < UDP_HDR_LEN) begin
            xerr = 1;
            return;
        end
        m_src  = {f[0], f[1]};
        m_dst  = {f[2], f[3]};
        len    = {f[4], f[5]};
        m_plen = len >= 8 ? 16'(len - 8) : 16'd0;
        if (len < 8) xerr = 1;
        else if (m_dst != 16'h1F90) xdrop = 1;
        else if (len > 8) begin
            xout = (len - 8 < n - 8) ? len - 8 : n - 8;
            xerr = (n - 8 < len - 8);
        end
    endtask

    initial begin
        bq_t fa, fb;
        int  xo, xe, xd, e0;
        tbl[0]  = '{16'h1234, 16'h1F90, 16'd12, 12, 4, 0, 0, 16'h1234, 16'h1F90, 16'd4};
        tbl[1]  = '{16'h1234, 16'h0050, 16'd12, 12, 0, 0, 1, 16'h1234, 16'h0050, 16'd4};
        tbl[2]  = '{16'hABCD, 16'h1F90, 16'd12, 18, 4, 0, 0, 16'hABCD, 16'h1F90, 16'd4};
        tbl[3]  = '{16'h0101, 16'h1F90, 16'd20, 13, 5, 1, 0, 16'h0101, 16'h1F90, 16'd12};
        tbl[4]  = '{16'h7777, 16'h1F90, 16'd12, 5,  0, 1, 0, 16'h0101, 16'h1F90, 16'd12};
        tbl[5]  = '{16'h0202, 16'h1F90, 16'd6,  8,  0, 1, 0, 16'h0202, 16'h1F90, 16'd0};
        tbl[6]  = '{16'h0303, 16'h1F90, 16'd8,  8,  0, 0, 0, 16'h0303, 16'h1F90, 16'd0};
        tbl[7]  = '{16'h0404, 16'h1F90, 16'd12, 1,  0, 1, 0, 16'h0303, 16'h1F90, 16'd0};
        tbl[8]  = '{16'h0505, 16'h0050, 16'd3,  8,  0, 1, 0, 16'h0505, 16'h0050, 16'd0};
        tbl[9]  = '{16'h0606, 16'h1F90, 16'd16, 8,  0, 1, 0, 16'h0606, 16'h1F90, 16'd8};
        tbl[10] = '{16'h0707, 16'h1F90, 16'd9,  9,  1, 0, 0, 16'h0707, 16'h1F90, 16'd1};

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        oq.delete(); e0 = ecnt;
        for (int i = 0; i < 5; i++) put(8'h40 + 8'(i), 1'b0, i == 4);
        repeat (3) @(posedge clk);
        #1;
        chk("nosop nout", oq.size(), 0);
        chk("nosop err", ecnt - e0, 0);

        foreach (tbl[i]) begin
            gaps = i[0];
            send_and_check(build(tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].n), $sformatf("tbl%0d", i),
                           tbl[i].xout, tbl[i].xerr, tbl[i].xdrop, tbl[i].xsrc, tbl[i].xdst, tbl[i].xplen);
        end

        gaps = 1'b1;
        fa = build(16'h1111, 16'h1F90, 16'd20, 20);
        fb = build(16'h2222, 16'h1F90, 16'd12, 12);
        oq.delete(); e0 = ecnt;
        for (int i = 0; i < 10; i++) put(fa[i], i == 0, 1'b0);
        send(fb);
        repeat (3) @(posedge clk);
        #1;
        chk("abort nout", oq.size(), 6);
        if (oq.size() == 6) begin
            chk("abort a_sop", oq[0][9], 1);
            chk("abort a_noeop", oq[1][8], 0);
            chk("abort a_data", oq[1][7:0], fa[9]);
            chk("abort b_sop", oq[2][9], 1);
            chk("abort b_data", oq[2][7:0], fb[8]);
            chk("abort b_eop", oq[5][8], 1);
        end
        chk("abort err", ecnt - e0, 1);
        chk("abort src", udp_src_port, 16'h2222);
        chk("abort plen", udp_payload_len, 4);

        for (int i = 0; i < 10; i++) put(fa[i], i == 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        oq.delete(); e0 = ecnt;
        for (int i = 10; i < 20; i++) put(fa[i], 1'b0, i == 19);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst rest nout", oq.size(), 0);
        chk("midrst rest err", ecnt - e0, 0);
        chk("midrst rest src", udp_src_port, 0);
        send_and_check(fb, "recover", 4, 0, 0, 16'h2222, 16'h1F90, 16'd4);

        m_src = 16'h2222; m_dst = 16'h1F90; m_plen = 16'd4;
        for (int t = 0; t < 120; t++) begin
            logic [15:0] s, d, l;
            int n;
            s = 16'($urandom);
            d = $urandom_range(0, 3) != 0 ? 16'h1F90 : 16'($urandom);
            l = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 10)) : 16'($urandom_range(8, 40));
            n = $urandom_range(1, int'(l) + 12);
            fa = build(s, d, l, n);
            for (int i = 6; i < fa.size(); i++) fa[i] = 8'($urandom);
            model(fa, xo, xe, xd);
            send_and_check(fa, $sformatf("rnd%0d", t), xo, xe, xd, m_src, m_dst, m_plen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
